// File: rtl/multi_account_payment_ctrl.sv
// Multi-account toll/payment controller.
// A transaction is paid by demand draft or by a stream of cash notes. Each
// account carries its own credit and debt from one transaction to the next.
//
// Handshake: i_start is a single-cycle request. It is taken only in IDLE with
// a legal i_mode. Completion is the one-cycle o_done pulse, which is raised in
// the first IDLE cycle after SUCCESS, FAIL or REFUND. A new i_start may be
// presented in that same cycle. The o_success, o_fail and o_refund result
// flags stay set until the next accepted start.
module multi_account_payment_ctrl #(
   parameter int AMT_W   = 16,
   parameter int N_ACCT  = 4,
   parameter int TIMEOUT = 255,
   localparam int ACCT_W = (N_ACCT > 1) ? $clog2(N_ACCT) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [ACCT_W-1:0] i_acct_id,
   input  logic [AMT_W-1:0]  i_due_amt,
   input  logic [AMT_W-1:0]  i_dd_amt,
   input  logic              i_note_valid,
   input  logic [3:0]        i_note_code,
   input  logic              i_cancel,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_success,
   output logic              o_fail,
   output logic              o_refund,
   output logic              o_bad_note,
   output logic [AMT_W-1:0]  o_tendered_amt,
   output logic [AMT_W-1:0]  o_paid_amt,
   output logic [AMT_W-1:0]  o_credit_out,
   output logic [AMT_W-1:0]  o_debt_out,
   output logic [2:0]        o_state
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DD_IN   = 3'd1,
      S_CASH_IN = 3'd2,
      S_CALC    = 3'd3,
      S_SUCCESS = 3'd4,
      S_FAIL    = 3'd5,
      S_REFUND  = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ACCT_W-1:0]   r_acct;
   logic [AMT_W-1:0]    r_due;
   logic [AMT_W-1:0]    r_tend;
   logic [CNT_W-1:0]    r_cnt;
   logic [AMT_W-1:0]    r_credit [N_ACCT];
   logic [AMT_W-1:0]    r_debt   [N_ACCT];
   logic                r_done, r_success, r_fail, r_refund, r_bad_note;
   logic [AMT_W-1:0]    r_paid, r_credit_out, r_debt_out;

   logic                w_note_ok, w_note_fin, w_note_bad, w_accept;
   logic [AMT_W-1:0]    w_denom;
   logic [AMT_W:0]      w_note_sum;
   logic [AMT_W-1:0]    w_note_sat;
   logic [AMT_W:0]      w_amt, w_due, w_diff;
   logic                w_ge;
   logic [AMT_W-1:0]    w_diff_sat;

   // Note decode. Codes 1..7 are denominations, 8 finishes the payment, and
   // anything else is rejected.
   always_comb begin
      w_note_ok  = i_note_valid && (i_note_code >= 4'd1) && (i_note_code <= 4'd7);
      w_note_fin = i_note_valid && (i_note_code == 4'd8);
      w_note_bad = i_note_valid && !w_note_ok && !w_note_fin;
      case (i_note_code)
         4'd1:    w_denom = AMT_W'(5);
         4'd2:    w_denom = AMT_W'(10);
         4'd3:    w_denom = AMT_W'(20);
         4'd4:    w_denom = AMT_W'(50);
         4'd5:    w_denom = AMT_W'(100);
         4'd6:    w_denom = AMT_W'(500);
         4'd7:    w_denom = AMT_W'(1000);
         default: w_denom = '0;
      endcase
      w_note_sum = {1'b0, r_tend} + {1'b0, w_denom};
      w_note_sat = w_note_sum[AMT_W] ? '1 : w_note_sum[AMT_W-1:0];
   end

   // Settlement arithmetic. One extra bit keeps the carry, and the stored
   // difference saturates.
   always_comb begin
      w_amt      = {1'b0, r_tend} + {1'b0, r_credit[r_acct]};
      w_due      = {1'b0, r_due} + {1'b0, r_debt[r_acct]};
      w_ge       = (w_amt >= w_due);
      w_diff     = w_ge ? (w_amt - w_due) : (w_due - w_amt);
      w_diff_sat = w_diff[AMT_W] ? '1 : w_diff[AMT_W-1:0];
   end

   // Next-state logic. Cancel outranks any note in the same cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start && i_mode == 2'b01)      w_next = S_DD_IN;
            else if (i_start && i_mode == 2'b10) w_next = S_CASH_IN;
         end
         S_DD_IN:   w_next = S_CALC;
         S_CASH_IN: begin
            if (i_cancel)         w_next = S_REFUND;
            else if (w_note_fin)  w_next = S_CALC;
            else if (!i_note_valid && r_cnt == CNT_W'(TIMEOUT - 1))
                                  w_next = S_REFUND;
         end
         S_CALC:    w_next = w_ge ? S_SUCCESS : S_FAIL;
         S_SUCCESS, S_FAIL, S_REFUND: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      w_accept = (r_state == S_IDLE) && (w_next != S_IDLE);
   end

   // State, balances, amounts and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_acct       <= '0;
         r_due        <= '0;
         r_tend       <= '0;
         r_cnt        <= '0;
         r_done       <= 1'b0;
         r_success    <= 1'b0;
         r_fail       <= 1'b0;
         r_refund     <= 1'b0;
         r_bad_note   <= 1'b0;
         r_paid       <= '0;
         r_credit_out <= '0;
         r_debt_out   <= '0;
         for (int i = 0; i < N_ACCT; i++) begin
            r_credit[i] <= '0;
            r_debt[i]   <= '0;
         end
      end else begin
         r_state    <= w_next;
         r_done     <= 1'b0;
         r_bad_note <= 1'b0;
         if (w_accept) begin
            r_acct    <= i_acct_id;
            r_due     <= i_due_amt;
            r_tend    <= '0;
            r_cnt     <= '0;
            r_success <= 1'b0;
            r_fail    <= 1'b0;
            r_refund  <= 1'b0;
         end
         case (r_state)
            S_DD_IN: r_tend <= i_dd_amt;
            S_CASH_IN: begin
               if (!i_cancel) begin
                  if (w_note_ok) begin
                     r_tend <= w_note_sat;
                     r_cnt  <= '0;
                  end else if (w_note_bad) begin
                     r_bad_note <= 1'b1;
                  end else if (!i_note_valid) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_CALC: begin
               r_credit[r_acct] <= w_ge ? w_diff_sat : '0;
               r_debt[r_acct]   <= w_ge ? '0 : w_diff_sat;
            end
            S_SUCCESS, S_FAIL: begin
               r_done       <= 1'b1;
               r_success    <= (r_state == S_SUCCESS);
               r_fail       <= (r_state == S_FAIL);
               r_paid       <= r_due;
               r_credit_out <= r_credit[r_acct];
               r_debt_out   <= r_debt[r_acct];
            end
            S_REFUND: begin
               r_done   <= 1'b1;
               r_refund <= 1'b1;
               r_paid   <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = r_done;
   assign o_success      = r_success;
   assign o_fail         = r_fail;
   assign o_refund       = r_refund;
   assign o_bad_note     = r_bad_note;
   assign o_tendered_amt = r_tend;
   assign o_paid_amt     = r_paid;
   assign o_credit_out   = r_credit_out;
   assign o_debt_out     = r_debt_out;
   assign o_state        = r_state;

endmodule

// File: tb/tb_multi_account_payment_ctrl.sv
// Directed bench for multi_account_payment_ctrl. Each scenario task drives its
// stimulus and checks the expected values computed by hand.
module tb_multi_account_payment_ctrl;
   localparam int AMT_W   = 16;
   localparam int N_ACCT  = 4;
   localparam int TIMEOUT = 255;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b0;
   logic              i_start = 1'b0;
   logic [1:0]        i_mode = '0;
   logic [1:0]        i_acct_id = '0;
   logic [AMT_W-1:0]  i_due_amt = '0;
   logic [AMT_W-1:0]  i_dd_amt = '0;
   logic              i_note_valid = 1'b0;
   logic [3:0]        i_note_code = '0;
   logic              i_cancel = 1'b0;
   logic              o_busy, o_done, o_success, o_fail, o_refund, o_bad_note;
   logic [AMT_W-1:0]  o_tendered_amt, o_paid_amt, o_credit_out, o_debt_out;
   logic [2:0]        o_state;

   int n_checks = 0;
   int n_pass   = 0;

   multi_account_payment_ctrl #(.AMT_W(AMT_W), .N_ACCT(N_ACCT), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
      .i_acct_id(i_acct_id), .i_due_amt(i_due_amt), .i_dd_amt(i_dd_amt),
      .i_note_valid(i_note_valid), .i_note_code(i_note_code), .i_cancel(i_cancel),
      .o_busy(o_busy), .o_done(o_done), .o_success(o_success), .o_fail(o_fail),
      .o_refund(o_refund), .o_bad_note(o_bad_note), .o_tendered_amt(o_tendered_amt),
      .o_paid_amt(o_paid_amt), .o_credit_out(o_credit_out), .o_debt_out(o_debt_out),
      .o_state(o_state)
   );

   // Clock
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start_txn(input logic [1:0] m, input logic [1:0] a,
                            input logic [AMT_W-1:0] due, input logic [AMT_W-1:0] dd);
      i_start = 1'b1; i_mode = m; i_acct_id = a; i_due_amt = due; i_dd_amt = dd;
      tick();
      i_start = 1'b0; i_mode = 2'b00;
   endtask

   task automatic send_note(input logic [3:0] c);
      i_note_valid = 1'b1; i_note_code = c;
      tick();
      i_note_valid = 1'b0; i_note_code = 4'd0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (o_done !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick(); tick();
      i_rst = 1'b0;
      n_checks++;
      if ({o_busy, o_done, o_success, o_fail, o_refund, o_bad_note} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000",
                  {o_busy, o_done, o_success, o_fail, o_refund, o_bad_note});
      else n_pass++;
      n_checks++;
      if ({o_tendered_amt, o_paid_amt, o_credit_out, o_debt_out} !== 64'd0 || o_state !== 3'd0)
         $display("FAIL reset_values: tend=%0d paid=%0d cr=%0d dt=%0d st=%0d want all 0",
                  o_tendered_amt, o_paid_amt, o_credit_out, o_debt_out, o_state);
      else n_pass++;
   endtask

   task automatic test_dd();
      int cyc;
      start_txn(2'b01, 2'd0, 16'd100, 16'd150);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 3) $display("FAIL dd_latency: got %0d want 3", cyc); else n_pass++;
      n_checks++;
      if ({o_success, o_fail, o_refund, o_busy} !== 4'b1000)
         $display("FAIL dd_flags: got %b want 1000", {o_success, o_fail, o_refund, o_busy});
      else n_pass++;
      n_checks++;
      if (o_credit_out !== 16'd50 || o_debt_out !== 16'd0)
         $display("FAIL dd_balance: cr=%0d dt=%0d want 50 0", o_credit_out, o_debt_out);
      else n_pass++;
      n_checks++;
      if (o_paid_amt !== 16'd100 || o_tendered_amt !== 16'd150)
         $display("FAIL dd_amounts: paid=%0d tend=%0d want 100 150", o_paid_amt, o_tendered_amt);
      else n_pass++;
      tick();
      n_checks++;
      if (o_done !== 1'b0 || o_success !== 1'b1)
         $display("FAIL dd_pulse: done=%b success=%b want 0 1", o_done, o_success);
      else n_pass++;
   endtask

   task automatic test_cash_fail_then_pay();
      int cyc;
      start_txn(2'b10, 2'd0, 16'd100, 16'd0);
      n_checks++;
      if (o_success !== 1'b0 || o_busy !== 1'b1 || o_tendered_amt !== 16'd0)
         $display("FAIL cash_accept: success=%b busy=%b tend=%0d want 0 1 0",
                  o_success, o_busy, o_tendered_amt);
      else n_pass++;
      send_note(4'd3);
      send_note(4'd3);
      n_checks++;
      if (o_tendered_amt !== 16'd40) $display("FAIL cash_sum: got %0d want 40", o_tendered_amt);
      else n_pass++;
      send_note(4'd8);
      wait_done(cyc);
      n_checks++;
      if (cyc !== 2) $display("FAIL cash_latency: got %0d want 2", cyc); else n_pass++;
      // 40 tendered + 50 credit = 90 against 100 due: debt 10
      n_checks++;
      if (o_fail !== 1'b1 || o_success !== 1'b0 || o_debt_out !== 16'd10 || o_credit_out !== 16'd0)
         $display("FAIL cash_underpay: fail=%b succ=%b dt=%0d cr=%0d want 1 0 10 0",
                  o_fail, o_success, o_debt_out, o_credit_out);
      else n_pass++;
      n_checks++;
      if (o_paid_amt !== 16'd100) $display("FAIL cash_fail_paid: got %0d want 100", o_paid_amt);
      else n_pass++;
      // 50 tendered against 0 due + 10 debt: credit 40
      start_txn(2'b10, 2'd0, 16'd0, 16'd0);
      send_note(4'd4);
      send_note(4'd8);
      wait_done(cyc);
      n_checks++;
      if (o_success !== 1'b1 || o_fail !== 1'b0 || o_debt_out !== 16'd0 || o_credit_out !== 16'd40)
         $display("FAIL cash_repay: succ=%b fail=%b dt=%0d cr=%0d want 1 0 0 40",
                  o_success, o_fail, o_debt_out, o_credit_out);
      else n_pass++;
      n_checks++;
      if (o_tendered_amt !== 16'd50 || o_paid_amt !== 16'd0)
         $display("FAIL cash_repay_amt: tend=%0d paid=%0d want 50 0", o_tendered_amt, o_paid_amt);
      else n_pass++;
   endtask

   task automatic test_cancel();
      int cyc;
      start_txn(2'b10, 2'd1, 16'd30, 16'd0);
      // A start during CASH_IN must be ignored.
      i_start = 1'b1; i_mode = 2'b01;
      send_note(4'd5);
      i_start = 1'b0; i_mode = 2'b00;
      n_checks++;
      if (o_state !== 3'd2 || o_tendered_amt !== 16'd100)
         $display("FAIL cancel_busy_start: st=%0d tend=%0d want 2 100", o_state, o_tendered_amt);
      else n_pass++;
      i_note_valid = 1'b1; i_note_code = 4'd6; i_cancel = 1'b1;
      tick();
      i_note_valid = 1'b0; i_note_code = 4'd0; i_cancel = 1'b0;
      wait_done(cyc);
      n_checks++;
      if (cyc !== 1) $display("FAIL cancel_latency: got %0d want 1", cyc); else n_pass++;
      n_checks++;
      if ({o_refund, o_success, o_fail} !== 3'b100 || o_tendered_amt !== 16'd100 || o_paid_amt !== 16'd0)
         $display("FAIL cancel_refund: flags=%b tend=%0d paid=%0d want 100 100 0",
                  {o_refund, o_success, o_fail}, o_tendered_amt, o_paid_amt);
      else n_pass++;
      start_txn(2'b01, 2'd1, 16'd0, 16'd0);
      wait_done(cyc);
      n_checks++;
      if (o_credit_out !== 16'd0 || o_debt_out !== 16'd0 || o_refund !== 1'b0)
         $display("FAIL cancel_acct1: cr=%0d dt=%0d refund=%b want 0 0 0",
                  o_credit_out, o_debt_out, o_refund);
      else n_pass++;
      start_txn(2'b01, 2'd0, 16'd0, 16'd0);
      wait_done(cyc);
      n_checks++;
      if (o_credit_out !== 16'd40 || o_debt_out !== 16'd0)
         $display("FAIL cancel_acct0: cr=%0d dt=%0d want 40 0", o_credit_out, o_debt_out);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int cyc;
      start_txn(2'b10, 2'd2, 16'd5, 16'd0);
      wait_done(cyc);
      n_checks++;
      if (cyc !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT + 1);
      else n_pass++;
      n_checks++;
      if (o_refund !== 1'b1 || o_tendered_amt !== 16'd0)
         $display("FAIL timeout_refund: refund=%b tend=%0d want 1 0", o_refund, o_tendered_amt);
      else n_pass++;
      start_txn(2'b10, 2'd2, 16'd5, 16'd0);
      repeat (TIMEOUT - 1) tick();
      send_note(4'd1);
      n_checks++;
      if (o_state !== 3'd2 || o_done !== 1'b0)
         $display("FAIL timeout_restart_state: st=%0d done=%b want 2 0", o_state, o_done);
      else n_pass++;
      wait_done(cyc);
      n_checks++;
      if (cyc !== TIMEOUT + 1) $display("FAIL timeout_restart_latency: got %0d want %0d", cyc, TIMEOUT + 1);
      else n_pass++;
      n_checks++;
      if (o_refund !== 1'b1 || o_tendered_amt !== 16'd5)
         $display("FAIL timeout_restart_refund: refund=%b tend=%0d want 1 5", o_refund, o_tendered_amt);
      else n_pass++;
   endtask

   task automatic test_bad_note_and_saturation();
      int cyc;
      start_txn(2'b10, 2'd3, 16'd0, 16'd0);
      i_note_valid = 1'b1; i_note_code = 4'd9;
      tick();
      n_checks++;
      if (o_bad_note !== 1'b1 || o_tendered_amt !== 16'd0)
         $display("FAIL bad_code9: bad=%b tend=%0d want 1 0", o_bad_note, o_tendered_amt);
      else n_pass++;
      i_note_code = 4'd0;
      tick();
      n_checks++;
      if (o_bad_note !== 1'b1 || o_tendered_amt !== 16'd0)
         $display("FAIL bad_code0: bad=%b tend=%0d want 1 0", o_bad_note, o_tendered_amt);
      else n_pass++;
      i_note_valid = 1'b0;
      tick();
      n_checks++;
      if (o_bad_note !== 1'b0) $display("FAIL bad_pulse: got %b want 0", o_bad_note);
      else n_pass++;
      for (int i = 0; i < 70; i++) begin
         send_note(4'd7);
         if (i == 64) begin
            n_checks++;
            if (o_tendered_amt !== 16'd65000)
               $display("FAIL sat_before: got %0d want 65000", o_tendered_amt);
            else n_pass++;
         end
      end
      n_checks++;
      if (o_tendered_amt !== 16'd65535) $display("FAIL sat_tendered: got %0d want 65535", o_tendered_amt);
      else n_pass++;
      send_note(4'd8);
      wait_done(cyc);
      n_checks++;
      if (o_success !== 1'b1 || o_credit_out !== 16'd65535 || o_debt_out !== 16'd0)
         $display("FAIL sat_settle: succ=%b cr=%0d dt=%0d want 1 65535 0",
                  o_success, o_credit_out, o_debt_out);
      else n_pass++;
   endtask

   task automatic test_reset_mid_and_bad_mode();
      int cyc;
      start_txn(2'b10, 2'd0, 16'd0, 16'd0);
      send_note(4'd4);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      n_checks++;
      if ({o_busy, o_done, o_success, o_fail, o_refund} !== 5'b0 || o_state !== 3'd0)
         $display("FAIL rst_mid_flags: got %b st=%0d want 00000 0",
                  {o_busy, o_done, o_success, o_fail, o_refund}, o_state);
      else n_pass++;
      n_checks++;
      if (o_tendered_amt !== 16'd0) $display("FAIL rst_mid_tend: got %0d want 0", o_tendered_amt);
      else n_pass++;
      i_start = 1'b1; i_mode = 2'b11;
      tick();
      i_start = 1'b0; i_mode = 2'b00;
      n_checks++;
      if (o_busy !== 1'b0 || o_state !== 3'd0)
         $display("FAIL bad_mode_idle: busy=%b st=%0d want 0 0", o_busy, o_state);
      else n_pass++;
      tick(); tick(); tick();
      n_checks++;
      if (o_done !== 1'b0) $display("FAIL bad_mode_done: got %b want 0", o_done);
      else n_pass++;
      // Account 0 held credit 40 before reset; it must now read 0.
      start_txn(2'b01, 2'd0, 16'd0, 16'd0);
      wait_done(cyc);
      n_checks++;
      if (o_success !== 1'b1 || o_credit_out !== 16'd0 || o_debt_out !== 16'd0)
         $display("FAIL rst_balances: succ=%b cr=%0d dt=%0d want 1 0 0",
                  o_success, o_credit_out, o_debt_out);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_dd();
      test_cash_fail_then_pay();
      test_cancel();
      test_timeout();
      test_bad_note_and_saturation();
      test_reset_mid_and_bad_mode();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
